// File: rtl/iir_pkg.sv
// iir_pkg: shared widths, saturation limits and the saturating round used by the IIR cascade
package iir_pkg;
  localparam int DW = 24;
  localparam int GW = 16;
  localparam int GFRAC = 14;
  localparam int PW = DW + GW;
  localparam logic signed [PW-1:0] RND = PW'(1) << (GFRAC - 1);
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
  typedef struct packed {
    logic [DW-1:0] data;
    logic sat;
  } rnd_t;
  function automatic rnd_t sat_round(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    logic ok;
    r = (p + RND) >>> GFRAC;
    // the value fits in DW bits only when everything above the DW sign bit is sign extension
    ok = (r[PW-1:DW-1] == '0) || (r[PW-1:DW-1] == '1);
    return '{data: ok ? r[DW-1:0] : (r[PW-1] ? SAT_MIN : SAT_MAX), sat: !ok};
  endfunction
endpackage

// File: rtl/iir_out_buffer_if.sv
// iir_out_buffer_if: valid/ready sample stream leaving the IIR output buffer
interface iir_out_buffer_if;
  import iir_pkg::*;
  logic [DW-1:0] m_data;
  logic m_valid;
  logic m_ready;
  modport master(output m_data, m_valid, input m_ready);
  modport slave(input m_data, m_valid, output m_ready);
endinterface

// File: rtl/iir_sync_fifo.sv
// iir_sync_fifo: single-clock FIFO with occupancy count and synchronous flush
module iir_sync_fifo #(
  parameter int DW = 24,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   fill
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign rd_data = mem[rp];
  assign full = fill == (AW+1)'(DEPTH);
  assign empty = fill == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      fill <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      fill <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 1'b1;
      end
      if (rd_en) rp <= rp + 1'b1;
      fill <= fill + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/iir_out_buffer.sv
// iir_out_buffer: gain, round and saturate the cascade output, then buffer it behind a valid/ready port
module iir_out_buffer
  import iir_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic signed [DW-1:0] data_in,
  input  logic                 data_valid_in,
  input  logic signed [GW-1:0] gain,
  iir_out_buffer_if.master     m,
  output logic [AW:0]          fill,
  output logic [15:0]          ovf_cnt,
  output logic [15:0]          sat_cnt,
  output logic                 ovf_flag
);
  logic signed [PW-1:0] p;
  logic v1, full, empty, rd, wr, drop;
  rnd_t r;
  assign r = sat_round(p);
  assign rd = m.m_valid && m.m_ready;
  // a full FIFO still takes the sample when a pop frees the slot on the same edge
  assign wr = v1 && (!full || rd);
  assign drop = v1 && full && !rd;
  assign m.m_valid = !empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p <= '0;
      v1 <= 1'b0;
      ovf_cnt <= '0;
      sat_cnt <= '0;
      ovf_flag <= 1'b0;
    end else if (clr) begin
      v1 <= 1'b0;
      ovf_cnt <= '0;
      sat_cnt <= '0;
      ovf_flag <= 1'b0;
    end else begin
      v1 <= data_valid_in;
      if (data_valid_in) p <= PW'(data_in) * PW'(gain);
      ovf_cnt <= ovf_cnt + 16'(drop && ovf_cnt != 16'hFFFF);
      sat_cnt <= sat_cnt + 16'(v1 && r.sat && sat_cnt != 16'hFFFF);
      ovf_flag <= ovf_flag | drop;
    end
  iir_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .wr_en(wr),
    .wr_data(r.data),
    .rd_en(rd),
    .rd_data(m.m_data),
    .full(full),
    .empty(empty),
    .fill(fill)
  );
endmodule
